dsp_mac_pipe: RTL and testbench

Three-stage pipelined fixed-point multiply-accumulate unit for the RISC-V DSP execute stage. It consumes the decoded MAC operands (mac_a, mac_b, mac_c), the mode, and the saturate/round controls. It produces mac_result and its overflow/underflow flags for write-back through a valid/ready handshake. An optional internal accumulator supports chained accumulate operations.

---
 rtl/dsp_mac_pipe_if.sv | 41 ++++
 rtl/dsp_mac_pipe.sv | 174 +++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - operand/result handshake bundle for dsp_mac_pipe
//
// Purpose: groups the input valid/ready channel (operands, mode, controls),
// the output valid/ready channel (result and flags) and the accumulator view.
// Ports (signals):
//   in_valid/in_ready   input-side handshake
//   mac_a, mac_b, mac_c operands (signed two's complement)
//   mac_mode            00 MUL, 01 MAC, 10 MSU, 11 ACC
//   saturate, round     result controls; acc_clr accumulator clear
//   out_valid/out_ready output-side handshake
//   mac_result, mac_overflow, mac_underflow, acc_value
// Modports: master drives operands and consumes results; slave is the unit.
interface dsp_mac_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0] mac_b;
  logic [DATA_WIDTH-1:0] mac_c;
  logic [1:0]            mac_mode;
  logic                  saturate;
  logic                  round;
  logic                  acc_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] mac_result;
  logic                  mac_overflow;
  logic                  mac_underflow;
  logic [DATA_WIDTH-1:0] acc_value;

  modport master (
    output in_valid, mac_a, mac_b, mac_c, mac_mode, saturate, round, acc_clr, out_ready,
    input  in_ready, out_valid, mac_result, mac_overflow, mac_underflow, acc_value
  );

  modport slave (
    input  in_valid, mac_a, mac_b, mac_c, mac_mode, saturate, round, acc_clr, out_ready,
    output in_ready, out_valid, mac_result, mac_overflow, mac_underflow, acc_value
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - three-stage pipelined fixed-point multiply-accumulate
//
// Purpose: stage 1 registers operands/controls, stage 2 forms the full signed
// product, stage 3 shifts/rounds, applies the mode, flags and clamps/wraps.
// Optional feature macro: DSP_MAC_ACC_EN enables the internal accumulator,
// ACC mode, acc_clr and acc_value. Without it mode 11 runs as MUL and
// acc_value reads 0.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dsp_mac_pipe_if.slave (handshakes, operands, result, flags)
module dsp_mac_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 15
) (
  input logic           clk,
  input logic           rst_n,
  dsp_mac_pipe_if.slave bus
);
  localparam int DW     = DATA_WIDTH;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int XW     = 2 * DATA_WIDTH + 2;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_MAC = 2'b01;
  localparam logic [1:0] MODE_MSU = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;

  localparam logic signed [XW-1:0] RND_HALF = (FRAC_BITS > 0) ? (XW'(1) << RND_SH) : XW'(0);
  localparam logic signed [XW-1:0] SAT_MAX  = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN  = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // A held result blocks every stage; nothing collapses bubbles.
  logic w_adv;
  logic r_s3_valid;
  assign w_adv        = !(r_s3_valid && !bus.out_ready);
  assign bus.in_ready = w_adv;

  logic [1:0] w_in_mode;
`ifdef DSP_MAC_ACC_EN
  assign w_in_mode = bus.mac_mode;
`else
  assign w_in_mode = (bus.mac_mode == MODE_ACC) ? MODE_MUL : bus.mac_mode;
`endif

  // Stage 1: operand capture
  logic                 r_s1_valid;
  logic signed [DW-1:0] r_s1_a, r_s1_b, r_s1_c;
  logic [1:0]           r_s1_mode;
  logic                 r_s1_sat, r_s1_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_mode  <= MODE_MUL;
      r_s1_sat   <= 1'b0;
      r_s1_rnd   <= 1'b0;
    end else if (w_adv) begin
      // in_ready equals w_adv, so in_valid here is exactly an input transfer
      r_s1_valid <= bus.in_valid;
      r_s1_a     <= bus.mac_a;
      r_s1_b     <= bus.mac_b;
      r_s1_c     <= bus.mac_c;
      r_s1_mode  <= w_in_mode;
      r_s1_sat   <= bus.saturate;
      r_s1_rnd   <= bus.round;
    end
  end

  // Stage 2: full-width signed product
  logic                 r_s2_valid;
  logic signed [PW-1:0] r_s2_prod;
  logic signed [DW-1:0] r_s2_c;
  logic [1:0]           r_s2_mode;
  logic                 r_s2_sat, r_s2_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_c     <= '0;
      r_s2_mode  <= MODE_MUL;
      r_s2_sat   <= 1'b0;
      r_s2_rnd   <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= $signed({{DW{r_s1_a[DW-1]}}, r_s1_a}) * $signed({{DW{r_s1_b[DW-1]}}, r_s1_b});
      r_s2_c     <= r_s1_c;
      r_s2_mode  <= r_s1_mode;
      r_s2_sat   <= r_s1_sat;
      r_s2_rnd   <= r_s1_rnd;
    end
  end

  // Stage 3 combinational datapath, carried at 2*DW+2 bits so no sum wraps
  logic signed [XW-1:0] w_prod_x, w_rnd_add, w_rounded, w_shifted;
  logic signed [XW-1:0] w_c_x, w_acc_x, w_full;
  logic                 w_ovf, w_unf;
  logic [DW-1:0]        w_res;

  assign w_prod_x  = {{2{r_s2_prod[PW-1]}}, r_s2_prod};
  assign w_rnd_add = r_s2_rnd ? RND_HALF : '0;
  assign w_rounded = w_prod_x + w_rnd_add;
  assign w_shifted = w_rounded >>> FRAC_BITS;
  assign w_c_x     = {{(XW-DW){r_s2_c[DW-1]}}, r_s2_c};

`ifdef DSP_MAC_ACC_EN
  logic [DW-1:0] r_acc;
  assign w_acc_x       = {{(XW-DW){r_acc[DW-1]}}, r_acc};
  assign bus.acc_value = r_acc;
`else
  logic w_unused_acc_clr;
  assign w_unused_acc_clr = bus.acc_clr;
  assign w_acc_x          = '0;
  assign bus.acc_value    = '0;
`endif

  always_comb begin
    w_full = w_shifted;
    case (r_s2_mode)
      MODE_MAC: w_full = w_c_x + w_shifted;
      MODE_MSU: w_full = w_c_x - w_shifted;
      MODE_ACC: w_full = w_acc_x + w_shifted;
      default:  w_full = w_shifted;
    endcase
  end

  assign w_ovf = (w_full > SAT_MAX);
  assign w_unf = (w_full < SAT_MIN);
  assign w_res = (r_s2_sat && w_ovf) ? SAT_MAX[DW-1:0] :
                 (r_s2_sat && w_unf) ? SAT_MIN[DW-1:0] : w_full[DW-1:0];

  // Stage 3 registers: result only moves on a real op, so outputs stay put on bubbles
  logic [DW-1:0] r_s3_result;
  logic          r_s3_ovf, r_s3_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid  <= 1'b0;
      r_s3_result <= '0;
      r_s3_ovf    <= 1'b0;
      r_s3_unf    <= 1'b0;
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_result <= w_res;
        r_s3_ovf    <= w_ovf;
        r_s3_unf    <= w_unf;
      end
    end
  end

`ifdef DSP_MAC_ACC_EN
  // Writing on the stage-3 load edge lets back-to-back ACC ops chain; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
    end else if (w_adv && r_s2_valid && (r_s2_mode == MODE_ACC)) begin
      r_acc <= w_res;
    end
  end
`endif

  assign bus.out_valid     = r_s3_valid;
  assign bus.mac_result    = r_s3_result;
  assign bus.mac_overflow  = r_s3_ovf;
  assign bus.mac_underflow = r_s3_unf;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed self-checking bench for dsp_mac_pipe
module tb_dsp_mac_pipe;
  localparam int DW = 32;
  localparam logic [1:0] M_MUL = 2'b00;
  localparam logic [1:0] M_MAC = 2'b01;
  localparam logic [1:0] M_MSU = 2'b10;
  localparam logic [1:0] M_ACC = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsp_mac_pipe_if #(.DATA_WIDTH(DW)) bus ();

  dsp_mac_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic sat, input logic rnd);
    bus.in_valid = v;
    bus.mac_mode = mode;
    bus.mac_a    = a;
    bus.mac_b    = b;
    bus.mac_c    = c;
    bus.saturate = sat;
    bus.round    = rnd;
  endtask

  // Single op with out_ready=1: checks two empty cycles then the result after edge k+2
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic sat, input logic rnd,
                        input logic [31:0] exp_r, input logic exp_o, input logic exp_u);
    drive(1'b1, mode, a, b, c, sat, rnd);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "/lat_k"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "/lat_k1"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "/valid"}, bus.out_valid, 1'b1);
    check({tag, "/result"}, bus.mac_result, exp_r);
    check({tag, "/ovf"}, bus.mac_overflow, exp_o);
    check({tag, "/unf"}, bus.mac_underflow, exp_u);
  endtask

  logic [31:0] acc_exp [4];
  logic [31:0] acc_final;
  logic [31:0] clr_res;
  logic [31:0] stall_exp [3];
  int          got;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef DSP_MAC_ACC_EN
    acc_exp[0] = 32'h0000_8000;
    acc_exp[1] = 32'h0001_0000;
    acc_exp[2] = 32'h0001_8000;
    acc_exp[3] = 32'h0002_0000;
    acc_final  = 32'h0002_0000;
    clr_res    = 32'h0002_8000;
`else
    for (int i = 0; i < 4; i++) acc_exp[i] = 32'h0000_8000;
    acc_final  = 32'h0;
    clr_res    = 32'h0000_8000;
`endif
    stall_exp[0] = 32'd2;
    stall_exp[1] = 32'd3;
    stall_exp[2] = 32'd4;

    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.acc_clr   = 1'b0;
    drive(1'b0, M_MUL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", bus.in_ready, 1'b1);
    check("reset/out_valid", bus.out_valid, 1'b0);
    check("reset/result", bus.mac_result, 32'h0);
    check("reset/ovf", bus.mac_overflow, 1'b0);
    check("reset/unf", bus.mac_underflow, 1'b0);
    check("reset/acc", bus.acc_value, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("q15_mul",   M_MUL, 32'h0000_4000, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'h0000_2000, 1'b0, 1'b0);
    run_op("rnd0",      M_MUL, 32'h0000_0001, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run_op("rnd1",      M_MUL, 32'h0000_0001, 32'h0000_4000, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    run_op("neg_rnd0",  M_MUL, 32'hFFFF_FFFF, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("neg_rnd1",  M_MUL, 32'hFFFF_FFFF, 32'h0000_4000, 32'h0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run_op("neg_mul",   M_MUL, 32'hFFFF_8000, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'hFFFF_C000, 1'b0, 1'b0);
    run_op("mac_plain", M_MAC, 32'h0000_8000, 32'h0000_8000, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_8100, 1'b0, 1'b0);
    run_op("mac_sat",   M_MAC, 32'h0000_8000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_op("mac_wrap",  M_MAC, 32'h0000_8000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h8000_7FFF, 1'b1, 1'b0);
    run_op("msu_sat",   M_MSU, 32'h0000_8000, 32'h0000_8000, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("msu_wrap",  M_MSU, 32'h0000_8000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_8000, 1'b0, 1'b1);
    run_op("mul_wrap",  M_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 32'hFFFE_0000, 1'b1, 1'b0);

    // Accumulator chain: four back-to-back ACC ops, a=b=1.0 in Q15 -> +0x8000 each
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    check("acc/cleared", bus.acc_value, 32'h0);
    drive(1'b1, M_ACC, 32'h0000_8000, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j < 3) drive(1'b1, M_ACC, 32'h0000_8000, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      if (j >= 2) begin
        check("acc/valid", bus.out_valid, 1'b1);
        check("acc/result", bus.mac_result, acc_exp[j-2]);
      end
    end
    check("acc/final", bus.acc_value, acc_final);

    // ACC op loading stage 3 on the same edge as acc_clr: old value used, clear wins
    drive(1'b1, M_ACC, 32'h0000_8000, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    check("clr_edge/result", bus.mac_result, clr_res);
    check("clr_edge/acc", bus.acc_value, 32'h0);

    // Stall: three ops in flight, hold out_ready low with a fourth op offered
    drive(1'b1, M_MUL, 32'h0000_8000, 32'd1, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, M_MUL, 32'h0000_8000, 32'd2, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, M_MUL, 32'h0000_8000, 32'd3, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("stall/first_valid", bus.out_valid, 1'b1);
    check("stall/first_result", bus.mac_result, 32'd1);
    bus.out_ready = 1'b0;
    drive(1'b1, M_MUL, 32'h0000_8000, 32'd4, 32'h0, 1'b0, 1'b0);
    #1;
    check("stall/in_ready_low", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall/held_valid", bus.out_valid, 1'b1);
      check("stall/held_result", bus.mac_result, 32'd1);
      check("stall/held_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("stall/in_ready_release", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) begin
        if (got < 3) check("stall/order", bus.mac_result, stall_exp[got]);
        got++;
      end
      @(posedge clk); #1;
    end
    check("stall/count", got, 3);

    // Reset with ops in flight: out_valid drops at once, nothing stale afterwards
    drive(1'b1, M_MUL, 32'h0000_8000, 32'd5, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, M_MUL, 32'h0000_8000, 32'd6, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid/pre_valid", bus.out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid/valid", bus.out_valid, 1'b0);
    check("rst_mid/result", bus.mac_result, 32'h0);
    check("rst_mid/in_ready", bus.in_ready, 1'b1);
    check("rst_mid/acc", bus.acc_value, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) got++;
    end
    check("rst_mid/no_stale", got, 0);

    run_op("post_rst", M_MUL, 32'h0000_4000, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'h0000_2000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
